axi_mem_arbiter: RTL and testbench

Upstream neighbour of the SRAM AXI-lite slave. It arbitrates between the instruction fetch unit (IFU, read-only) and the load/store unit (LSU, read/write) and converts their simple request/response interfaces into one AXI-lite master port. Only one transaction is outstanding at a time. Arbitration is round-robin, or fixed LSU priority when round-robin is disabled.

---
 rtl/axi_mem_arbiter.sv | 172 +++++++++++++++++
 tb/tb_axi_mem_arbiter.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_mem_arbiter.sv
// axi_mem_arbiter: arbitrates IFU reads and LSU reads/writes onto one AXI-lite
// master port, one transaction outstanding at a time.
module axi_mem_arbiter #(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned DATA_W = 64,
  parameter bit          RR_EN  = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ifu_req_valid,
  output logic                  ifu_req_ready,
  input  logic [ADDR_W-1:0]     ifu_addr,
  output logic                  ifu_resp_valid,
  output logic [DATA_W-1:0]     ifu_rdata,
  input  logic                  lsu_req_valid,
  output logic                  lsu_req_ready,
  input  logic                  lsu_wen,
  input  logic [ADDR_W-1:0]     lsu_addr,
  input  logic [DATA_W-1:0]     lsu_wdata,
  input  logic [DATA_W/8-1:0]   lsu_wstrb,
  output logic                  lsu_resp_valid,
  output logic [DATA_W-1:0]     lsu_rdata,
  output logic                  lsu_resp_err,
  output logic                  ar_valid,
  input  logic                  ar_ready,
  output logic [ADDR_W-1:0]     araddr,
  input  logic                  r_valid,
  output logic                  r_ready,
  input  logic [DATA_W-1:0]     rdata,
  output logic                  aw_valid,
  input  logic                  aw_ready,
  output logic [ADDR_W-1:0]     awaddr,
  output logic                  w_valid,
  input  logic                  w_ready,
  output logic [DATA_W-1:0]     wdata,
  output logic [DATA_W/8-1:0]   wstrb,
  input  logic                  bvalid,
  output logic                  bready,
  input  logic [1:0]            bresp
);

  localparam int unsigned STRB_W = DATA_W / 8;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_AR   = 3'd1,
    S_R    = 3'd2,
    S_AW   = 3'd3,
    S_B    = 3'd4
  } state_t;

  state_t              state, state_nxt;
  logic                grant;       // 0 = IFU, 1 = LSU
  logic                last_grant;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [STRB_W-1:0]   wstrb_q;
  logic                wen_q;
  logic                lsu_wins;
  logic                accept_ifu;
  logic                accept_lsu;

  // Winner selection: a tie goes to whoever was not granted last (or always LSU)
  always_comb begin
    lsu_wins   = lsu_req_valid & (~ifu_req_valid | ~last_grant | ~RR_EN);
    accept_lsu = (state == S_IDLE) & ~reset & lsu_wins;
    accept_ifu = (state == S_IDLE) & ~reset & ifu_req_valid & ~lsu_wins;
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Request latch and arbitration history
  always_ff @(posedge clk) begin
    if (reset) begin
      grant      <= 1'b0;
      last_grant <= 1'b1;
      addr_q     <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      wen_q      <= 1'b0;
    end else if (accept_lsu) begin
      grant      <= 1'b1;
      last_grant <= 1'b1;
      addr_q     <= lsu_addr;
      wdata_q    <= lsu_wdata;
      wstrb_q    <= lsu_wstrb;
      wen_q      <= lsu_wen;
    end else if (accept_ifu) begin
      grant      <= 1'b0;
      last_grant <= 1'b0;
      addr_q     <= ifu_addr;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      wen_q      <= 1'b0;
    end
  end

  // Next state and all handshake/response outputs; everything is forced low in reset
  always_comb begin
    state_nxt      = state;
    ifu_req_ready  = 1'b0;
    lsu_req_ready  = 1'b0;
    ifu_resp_valid = 1'b0;
    ifu_rdata      = '0;
    lsu_resp_valid = 1'b0;
    lsu_rdata      = '0;
    lsu_resp_err   = 1'b0;
    ar_valid       = 1'b0;
    araddr         = '0;
    r_ready        = 1'b0;
    aw_valid       = 1'b0;
    awaddr         = '0;
    w_valid        = 1'b0;
    wdata          = '0;
    wstrb          = '0;
    bready         = 1'b0;

    case (state)
      S_IDLE: begin
        ifu_req_ready = accept_ifu;
        lsu_req_ready = accept_lsu;
        if (accept_lsu)      state_nxt = lsu_wen ? S_AW : S_AR;
        else if (accept_ifu) state_nxt = S_AR;
      end
      S_AR: begin
        ar_valid = ~reset;
        araddr   = reset ? '0 : addr_q;
        if (ar_ready) state_nxt = S_R;
      end
      S_R: begin
        r_ready = ~reset;
        if (r_valid) begin
          state_nxt = S_IDLE;
          if (!reset) begin
            if (grant & ~wen_q) begin
              lsu_resp_valid = 1'b1;
              lsu_rdata      = rdata;
            end else begin
              ifu_resp_valid = 1'b1;
              ifu_rdata      = rdata;
            end
          end
        end
      end
      S_AW: begin
        // Address and data are offered together and retire together
        aw_valid = ~reset;
        w_valid  = ~reset;
        awaddr   = reset ? '0 : addr_q;
        wdata    = reset ? '0 : wdata_q;
        wstrb    = reset ? '0 : wstrb_q;
        if (aw_ready & w_ready) state_nxt = S_B;
      end
      S_B: begin
        bready = ~reset;
        if (bvalid) begin
          state_nxt = S_IDLE;
          if (!reset) begin
            lsu_resp_valid = 1'b1;
            lsu_resp_err   = (bresp != 2'b00);
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_axi_mem_arbiter.sv
// Self-checking bench for axi_mem_arbiter: directed scenarios plus randomized
// traffic against a transaction-level reference model and a behavioural slave.
module tb_axi_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid;
  logic [63:0] ifu_addr, ifu_rdata;
  logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_resp_valid, lsu_resp_err;
  logic [63:0] lsu_addr, lsu_wdata, lsu_rdata;
  logic [7:0]  lsu_wstrb;
  logic        ar_valid, ar_ready, r_valid, r_ready;
  logic [63:0] araddr, rdata;
  logic        aw_valid, aw_ready, w_valid, w_ready, bvalid, bready;
  logic [63:0] awaddr, wdata;
  logic [7:0]  wstrb;
  logic [1:0]  bresp;

  // Fixed-priority instance sharing the same inputs
  logic        f_ifu_req_ready, f_ifu_resp_valid, f_lsu_req_ready, f_lsu_resp_valid, f_lsu_resp_err;
  logic [63:0] f_ifu_rdata, f_lsu_rdata, f_araddr, f_awaddr, f_wdata;
  logic        f_ar_valid, f_r_ready, f_aw_valid, f_w_valid, f_bready;
  logic [7:0]  f_wstrb;

  always #5 clk = ~clk;

  axi_mem_arbiter #(.ADDR_W(64), .DATA_W(64), .RR_EN(1'b1)) dut (
    .clk(clk), .reset(reset),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
    .ifu_resp_valid(ifu_resp_valid), .ifu_rdata(ifu_rdata),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_wen(lsu_wen),
    .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata), .lsu_wstrb(lsu_wstrb),
    .lsu_resp_valid(lsu_resp_valid), .lsu_rdata(lsu_rdata), .lsu_resp_err(lsu_resp_err),
    .ar_valid(ar_valid), .ar_ready(ar_ready), .araddr(araddr),
    .r_valid(r_valid), .r_ready(r_ready), .rdata(rdata),
    .aw_valid(aw_valid), .aw_ready(aw_ready), .awaddr(awaddr),
    .w_valid(w_valid), .w_ready(w_ready), .wdata(wdata), .wstrb(wstrb),
    .bvalid(bvalid), .bready(bready), .bresp(bresp)
  );

  axi_mem_arbiter #(.ADDR_W(64), .DATA_W(64), .RR_EN(1'b0)) u_fix (
    .clk(clk), .reset(reset),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(f_ifu_req_ready), .ifu_addr(ifu_addr),
    .ifu_resp_valid(f_ifu_resp_valid), .ifu_rdata(f_ifu_rdata),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(f_lsu_req_ready), .lsu_wen(lsu_wen),
    .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata), .lsu_wstrb(lsu_wstrb),
    .lsu_resp_valid(f_lsu_resp_valid), .lsu_rdata(f_lsu_rdata), .lsu_resp_err(f_lsu_resp_err),
    .ar_valid(f_ar_valid), .ar_ready(ar_ready), .araddr(f_araddr),
    .r_valid(r_valid), .r_ready(f_r_ready), .rdata(rdata),
    .aw_valid(f_aw_valid), .aw_ready(aw_ready), .awaddr(f_awaddr),
    .w_valid(f_w_valid), .w_ready(w_ready), .wdata(f_wdata), .wstrb(f_wstrb),
    .bvalid(bvalid), .bready(f_bready), .bresp(bresp)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Shared memories: slave storage and reference-model storage (16 words from 0x8000_0000)
  logic [63:0] smem [16];
  logic [63:0] rmem [16];

  // Slave configuration
  int wait_max = 0;
  int hold_ar  = 0;
  int r_hold   = 0;

  // Requester state
  bit rand_en = 0;
  int p_req   = 0;
  bit ifu_pend = 0, lsu_pend = 0;
  bit rst_req = 1;

  // Reference model state
  int          cyc = 0, acc_cyc = 0;
  bit          busy = 0, exp_who = 0, exp_wen = 0, ar_done = 0, aw_done = 0, last_g = 1;
  logic [63:0] exp_addr = '0, exp_data = '0;
  bit          exp_err = 0;
  bit          lat_chk = 0;
  int          n_ifu_acc = 0, n_lsu_acc = 0, f_lsu_acc = 0;
  bit          prev_who = 0;
  bit          rr_phase = 0;
  int          rr_seen = 0;

  function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] d,
                                        input logic [7:0] s);
    logic [63:0] r;
    r = old;
    for (int i = 0; i < 8; i++) if (s[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Behavioural AXI-lite slave: handshakes sampled before the edge, responses driven after it
  initial begin : slave
    logic s_ar, s_aw, s_r, s_b, s_rst;
    logic [63:0] a_addr, w_addr, w_d, r_word;
    logic [7:0] w_s;
    logic [1:0] b_code;
    bit r_pend, b_pend;
    int r_cnt, b_cnt;
    r_pend = 0; b_pend = 0; r_cnt = 0; b_cnt = 0; r_word = '0; b_code = 2'b00;
    ar_ready = 0; r_valid = 0; rdata = '0; aw_ready = 0; w_ready = 0; bvalid = 0; bresp = 2'b00;
    forever begin
      @(negedge clk);
      s_ar = ar_valid & ar_ready;
      s_aw = aw_valid & w_valid & aw_ready & w_ready;
      s_r  = r_valid & r_ready;
      s_b  = bvalid & bready;
      s_rst = reset;
      a_addr = araddr; w_addr = awaddr; w_d = wdata; w_s = wstrb;
      @(posedge clk); #1;
      if (s_rst) begin
        r_pend = 0; b_pend = 0; r_valid = 0; bvalid = 0; rdata = '0; bresp = 2'b00;
      end else begin
        if (s_r) begin r_valid = 0; rdata = '0; end
        if (s_b) begin bvalid = 0; bresp = 2'b00; end
        if (s_ar) begin
          r_pend = 1;
          r_word = smem[a_addr[6:3]];
          r_cnt  = (r_hold != 0) ? r_hold : ((wait_max != 0) ? $urandom_range(0, wait_max) : 0);
        end
        if (s_aw) begin
          smem[w_addr[6:3]] = merge(smem[w_addr[6:3]], w_d, w_s);
          b_pend = 1;
          b_code = w_addr[5] ? 2'b10 : 2'b00;
          b_cnt  = (wait_max != 0) ? $urandom_range(0, wait_max) : 0;
        end
        if (r_pend) begin
          if (r_cnt == 0) begin r_valid = 1; rdata = r_word; r_pend = 0; end
          else r_cnt--;
        end
        if (b_pend) begin
          if (b_cnt == 0) begin bvalid = 1; bresp = b_code; b_pend = 0; end
          else b_cnt--;
        end
      end
      if (hold_ar > 0) begin ar_ready = 0; hold_ar--; end
      else ar_ready = (wait_max == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      aw_ready = (wait_max == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      w_ready  = (wait_max == 0) ? 1'b1 : 1'($urandom_range(0, 1));
    end
  end

  task automatic issue_ifu(input logic [63:0] a);
    ifu_pend = 1; ifu_addr = a;
  endtask

  task automatic issue_lsu(input bit we, input logic [63:0] a, input logic [63:0] d,
                           input logic [7:0] s);
    lsu_pend = 1; lsu_wen = we; lsu_addr = a; lsu_wdata = d; lsu_wstrb = s;
  endtask

  task automatic drive();
    if (rand_en && !ifu_pend && $urandom_range(0, 99) < p_req)
      issue_ifu(64'h8000_0000 + 64'($urandom_range(0, 15)) * 8);
    if (rand_en && !lsu_pend && $urandom_range(0, 99) < p_req)
      issue_lsu(1'($urandom_range(0, 1)), 64'h8000_0000 + 64'($urandom_range(0, 15)) * 8,
                {$urandom, $urandom}, 8'($urandom));
    reset = rst_req;
    ifu_req_valid = ifu_pend;
    lsu_req_valid = lsu_pend;
  endtask

  // Compare every DUT output against what the transaction model predicts for this cycle
  task automatic check_cycle();
    bit lw, e_ifu, e_lsu, e_arv, e_awv, e_rr, e_br, e_ir, e_lr;
    cyc++;
    lw    = lsu_req_valid && (!ifu_req_valid || !last_g);
    e_ifu = !reset && !busy && ifu_req_valid && !lw;
    e_lsu = !reset && !busy && lw;
    e_arv = !reset && busy && !exp_wen && !ar_done;
    e_awv = !reset && busy && exp_wen && !aw_done;
    e_rr  = !reset && busy && !exp_wen && ar_done;
    e_br  = !reset && busy && exp_wen && aw_done;
    e_ir  = e_rr && r_valid && !exp_who;
    e_lr  = (e_rr && r_valid && exp_who) || (e_br && bvalid);

    chk("ifu_req_ready", ifu_req_ready, e_ifu);
    chk("lsu_req_ready", lsu_req_ready, e_lsu);
    chk("ar_valid", ar_valid, e_arv);
    chk("aw_valid", aw_valid, e_awv);
    chk("w_valid", w_valid, e_awv);
    chk("r_ready", r_ready, e_rr);
    chk("bready", bready, e_br);
    chk("ifu_resp_valid", ifu_resp_valid, e_ir);
    chk("ifu_rdata", ifu_rdata, e_ir ? exp_data : 64'h0);
    chk("lsu_resp_valid", lsu_resp_valid, e_lr);
    chk("lsu_rdata", lsu_rdata, (e_lr && !exp_wen) ? exp_data : 64'h0);
    chk("lsu_resp_err", lsu_resp_err, (e_lr && exp_wen) ? exp_err : 1'b0);
    if (e_arv) chk("araddr", araddr, exp_addr);
    if (e_awv) begin
      chk("awaddr", awaddr, exp_addr);
      chk("wdata", wdata, exp_data);
    end
    if (reset) begin
      chk("rst_araddr", araddr, 64'h0);
      chk("rst_awaddr", awaddr, 64'h0);
      chk("rst_wdata", wdata, 64'h0);
      chk("rst_wstrb", wstrb, 64'h0);
    end
    if (!reset && lsu_req_valid) chk("fix_ifu_ready", f_ifu_req_ready, 1'b0);
    if (!reset && f_lsu_req_ready && lsu_req_valid) f_lsu_acc++;

    if (reset) begin
      busy = 0; last_g = 1; ar_done = 0; aw_done = 0;
    end else begin
      if (e_arv && ar_ready) ar_done = 1;
      if (e_awv && aw_ready && w_ready) aw_done = 1;
      if (e_ir || e_lr) begin
        if (lat_chk) chk("latency", 64'(cyc - acc_cyc), 64'd2);
        busy = 0;
      end
      if (busy && (cyc - acc_cyc) > 200) begin
        chk("txn_timeout", 64'(cyc - acc_cyc), 64'd0);
        busy = 0;
      end
      if (e_ifu || e_lsu) begin
        busy = 1; acc_cyc = cyc; ar_done = 0; aw_done = 0;
        exp_who = e_lsu;
        if (rr_phase) begin
          if (rr_seen > 0) chk("rr_alternate", exp_who, !prev_who);
          rr_seen++;
        end
        prev_who = exp_who;
        last_g = exp_who;
        if (e_lsu) begin
          n_lsu_acc++;
          exp_wen  = lsu_wen;
          exp_addr = lsu_addr;
          if (lsu_wen) begin
            rmem[lsu_addr[6:3]] = merge(rmem[lsu_addr[6:3]], lsu_wdata, lsu_wstrb);
            exp_data = lsu_wdata;
            exp_err  = lsu_addr[5];
          end else begin
            exp_data = rmem[lsu_addr[6:3]];
            exp_err  = 0;
          end
          lsu_pend = 0;
        end else begin
          n_ifu_acc++;
          exp_wen  = 0;
          exp_addr = ifu_addr;
          exp_data = rmem[ifu_addr[6:3]];
          exp_err  = 0;
          ifu_pend = 0;
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
    drive();
    @(negedge clk);
    check_cycle();
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && (busy || ifu_pend || lsu_pend); i++) step();
    chk("drain", 64'({busy, ifu_pend, lsu_pend}), 64'd0);
  endtask

  initial begin : stim
    int ni, nl;
    reset = 1; ifu_req_valid = 0; lsu_req_valid = 0; ifu_addr = '0;
    lsu_wen = 0; lsu_addr = '0; lsu_wdata = '0; lsu_wstrb = '0;
    for (int i = 0; i < 16; i++) begin
      smem[i] = 64'hA5A5_0000_0000_0000 | 64'(i);
      rmem[i] = smem[i];
    end
    smem[0] = 64'h1122_3344_5566_7788;
    rmem[0] = 64'h1122_3344_5566_7788;

    // Reset with both requesting: nothing accepted, all outputs quiet
    issue_ifu(64'h8000_0008);
    issue_lsu(1'b0, 64'h8000_0018, 64'h0, 8'h00);
    rst_req = 1;
    repeat (3) step();
    rst_req = 0;
    step();
    chk("first_tie_ifu", 64'(n_ifu_acc), 64'd1);
    drain();

    // Zero-wait single transactions with exact latency
    lat_chk = 1;
    issue_ifu(64'h8000_0000);
    drain();
    issue_lsu(1'b1, 64'h8000_0010, 64'h0000_0000_DEAD_BEEF, 8'h0F);
    drain();
    issue_ifu(64'h8000_0010);
    drain();
    chk("mem_merge", smem[2], 64'hA5A5_0000_DEAD_BEEF);
    issue_lsu(1'b1, 64'h8000_0020, 64'h0123_4567_89AB_CDEF, 8'hFF);
    drain();
    issue_lsu(1'b0, 64'h8000_0020, 64'h0, 8'h00);
    drain();

    // Round-robin: both requesting every cycle
    rand_en = 1; p_req = 100; rr_phase = 1; rr_seen = 0;
    ni = n_ifu_acc; nl = n_lsu_acc;
    repeat (60) step();
    rr_phase = 0; rand_en = 0;
    drain();
    ni = n_ifu_acc - ni; nl = n_lsu_acc - nl;
    chk("rr_balance", 64'((ni > nl ? ni - nl : nl - ni) <= 1), 64'd1);
    lat_chk = 0;

    // ar_ready withheld for three cycles while LSU also waits
    hold_ar = 4;
    issue_ifu(64'h8000_0030);
    step();
    issue_lsu(1'b0, 64'h8000_0038, 64'h0, 8'h00);
    drain();

    // Randomized traffic with a stalling slave
    wait_max = 3; rand_en = 1; p_req = 40;
    repeat (1500) step();
    rand_en = 0;
    drain();

    // Reset while waiting in R: transaction dropped, no response pulse
    r_hold = 5;
    issue_ifu(64'h8000_0040);
    for (int i = 0; i < 100 && !(busy && ar_done); i++) step();
    chk("reached_r", 64'(busy && ar_done), 64'd1);
    rst_req = 1;
    repeat (2) step();
    rst_req = 0;
    r_hold = 0; wait_max = 0;
    repeat (8) step();
    chk("post_reset_idle", 64'(busy), 64'd0);
    issue_ifu(64'h8000_0048);
    issue_lsu(1'b0, 64'h8000_0050, 64'h0, 8'h00);
    ni = n_ifu_acc;
    step();
    chk("post_reset_tie_ifu", 64'(n_ifu_acc - ni), 64'd1);
    drain();
    chk("fix_lsu_granted", 64'(f_lsu_acc > 0), 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
